dual_bus_arbiter: RTL

- Central arbiter for the shared Data and Instruction buses of the multicore MIPS32 system.
- Receives one bus request per core per bus from the per-core arbitration submodules and returns one-hot grants.
- Each bus has its own round-robin state machine. The two buses are arbitrated independently and can be owned by different cores in the same cycle.
- Guarantees a dead cycle with all grants low between owners, so that no two submodules ever drive the tri-stated bus at once.

---
 rtl/dual_bus_arbiter_if.sv | 34 +++
 rtl/dual_bus_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dual_bus_arbiter_if.sv
// Request/grant bundle between the per-core bus submodules and the central
// Data/Instruction bus arbiter.
interface dual_bus_arbiter_if #(
    parameter int N_CORES = 4
);
    localparam int OW = $clog2(N_CORES);

    logic [N_CORES-1:0] D_Bus_RQ;
    logic [N_CORES-1:0] I_Bus_RQ;
    logic               Bus_DataMem_Ready;
    logic               Bus_InstMem_Ready;
    logic [N_CORES-1:0] D_Bus_GRANT;
    logic [N_CORES-1:0] I_Bus_GRANT;
    logic [OW-1:0]      D_Bus_Owner;
    logic [OW-1:0]      I_Bus_Owner;
    logic               D_Bus_Busy;
    logic               I_Bus_Busy;
    logic               D_Bus_Timeout;
    logic               I_Bus_Timeout;

    // Arbiter side.
    modport master (
        input  D_Bus_RQ, I_Bus_RQ, Bus_DataMem_Ready, Bus_InstMem_Ready,
        output D_Bus_GRANT, I_Bus_GRANT, D_Bus_Owner, I_Bus_Owner,
        output D_Bus_Busy, I_Bus_Busy, D_Bus_Timeout, I_Bus_Timeout
    );

    // Requesting cores and memory side.
    modport slave (
        output D_Bus_RQ, I_Bus_RQ, Bus_DataMem_Ready, Bus_InstMem_Ready,
        input  D_Bus_GRANT, I_Bus_GRANT, D_Bus_Owner, I_Bus_Owner,
        input  D_Bus_Busy, I_Bus_Busy, D_Bus_Timeout, I_Bus_Timeout
    );
endinterface

// File: rtl/dual_bus_arbiter.sv
// Round-robin arbiter for the shared Data and Instruction buses, one FSM per bus
// with a forced dead cycle between owners. ARB_TIMEOUT_EN adds grant revocation.

module dual_bus_arbiter_fsm #(
    parameter int N_CORES  = 4,
    parameter int HOLD_MAX = 255
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [N_CORES-1:0]           rq,
    input  logic                         ready,
    output logic [N_CORES-1:0]           grant,
    output logic [$clog2(N_CORES)-1:0]   owner,
    output logic                         busy,
    output logic                         timeout
);
    localparam int OW = $clog2(N_CORES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [OW-1:0]      ptr, ptr_n, owner_n, owner_inc, pick;
    logic [N_CORES-1:0] grant_n;
    logic               busy_n, found;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);
    logic [HOLD_W-1:0] hold, hold_n;
    logic              timeout_n;
`else
    // Ready only matters for the revocation counter.
    logic unused_ready;
    assign unused_ready = ready & (HOLD_MAX > 0);
    assign timeout      = 1'b0;
`endif

    // First requester at or after ptr, wrapping modulo N_CORES.
    always_comb begin
        int slot;
        slot  = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < N_CORES; i++) begin
            slot = int'(ptr) + i;
            if (slot >= N_CORES) slot -= N_CORES;
            if (!found && rq[slot[OW-1:0]]) begin
                found = 1'b1;
                pick  = slot[OW-1:0];
            end
        end
    end

    assign owner_inc = (owner == OW'(N_CORES - 1)) ? '0 : owner + 1'b1;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        owner_n   = owner;
        grant_n   = '0;
        busy_n    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_n    = hold;
        timeout_n = 1'b0;
`endif
        unique case (state)
            IDLE, TURN: begin
                state_n = IDLE;
                if (found) begin
                    state_n       = GRANT;
                    owner_n       = pick;
                    grant_n[pick] = 1'b1;
                    busy_n        = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_n        = '0;
`endif
                end
            end
            GRANT: begin
                if (!rq[owner]) begin
                    state_n = TURN;
                    ptr_n   = owner_inc;
                end
`ifdef ARB_TIMEOUT_EN
                else if (!ready && hold == HOLD_W'(HOLD_MAX)) begin
                    state_n   = TURN;
                    ptr_n     = owner_inc;
                    timeout_n = 1'b1;
                end
`endif
                else begin
                    grant_n[owner] = 1'b1;
                    busy_n         = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_n         = ready ? '0 : hold + 1'b1;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            grant   <= '0;
            busy    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold    <= '0;
            timeout <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            owner   <= owner_n;
            grant   <= grant_n;
            busy    <= busy_n;
`ifdef ARB_TIMEOUT_EN
            hold    <= hold_n;
            timeout <= timeout_n;
`endif
        end
    end

    // A grant may only persist or drop to zero; a new owner never follows directly.
    a_onehot: assert property (@(posedge clock) disable iff (!reset_n) $onehot0(grant));
    a_dead_cycle: assert property (@(posedge clock) disable iff (!reset_n)
        (|grant) |=> ((grant == $past(grant)) || (grant == '0)));
    a_busy: assert property (@(posedge clock) busy == (|grant));
endmodule

module dual_bus_arbiter #(
    parameter int N_CORES  = 4,
    parameter int HOLD_MAX = 255
) (
    input  logic                clock,
    input  logic                reset_n,
    dual_bus_arbiter_if.master  bus
);
    dual_bus_arbiter_fsm #(
        .N_CORES  (N_CORES),
        .HOLD_MAX (HOLD_MAX)
    ) u_d_bus (
        .clock   (clock),
        .reset_n (reset_n),
        .rq      (bus.D_Bus_RQ),
        .ready   (bus.Bus_DataMem_Ready),
        .grant   (bus.D_Bus_GRANT),
        .owner   (bus.D_Bus_Owner),
        .busy    (bus.D_Bus_Busy),
        .timeout (bus.D_Bus_Timeout)
    );

    dual_bus_arbiter_fsm #(
        .N_CORES  (N_CORES),
        .HOLD_MAX (HOLD_MAX)
    ) u_i_bus (
        .clock   (clock),
        .reset_n (reset_n),
        .rq      (bus.I_Bus_RQ),
        .ready   (bus.Bus_InstMem_Ready),
        .grant   (bus.I_Bus_GRANT),
        .owner   (bus.I_Bus_Owner),
        .busy    (bus.I_Bus_Busy),
        .timeout (bus.I_Bus_Timeout)
    );
endmodule
